// File: rtl/mmio_ctrl_wait.sv
// MMIO slot controller: decodes slot/register, strobes one slot until it reports ready,
// and completes each access with a one-cycle mmio_ready pulse, an error flag on timeout or unmapped slot.
module mmio_ctrl_wait #(
  parameter int            N_SLOTS  = 64,
  parameter int            SLOT_AW  = 6,
  parameter int            REG_AW   = 5,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mmio_cs,
  input  logic                           mmio_wr,
  input  logic                           mmio_rd,
  input  logic [SLOT_AW+REG_AW-1:0]      mmio_addr,
  input  logic [DW-1:0]                  mmio_wr_data,
  output logic [DW-1:0]                  mmio_rd_data,
  output logic                           mmio_ready,
  output logic                           mmio_err,
  output logic [15:0]                    err_count,
  output logic [N_SLOTS-1:0]             slot_cs_array,
  output logic                           slot_mem_rd,
  output logic                           slot_mem_wr,
  output logic [REG_AW-1:0]              slot_reg_addr,
  output logic [DW-1:0]                  slot_wr_data,
  input  logic [N_SLOTS-1:0][DW-1:0]     slot_rd_data_array,
  input  logic [N_SLOTS-1:0]             slot_ready_array
);

  // state  | meaning
  // IDLE   | waiting for mmio_cs with rd or wr; request latched on accept
  // ACCESS | slot strobed, wait counter running until ready or timeout
  // DONE   | mmio_ready pulse, mmio_err valid, error counter updated
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [SLOT_AW-1:0]  slot_q, slot_d;
  logic                mapped_q, mapped_d;
  logic [REG_AW-1:0]   reg_q, reg_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [CW-1:0]       wait_q, wait_d;
  logic                err_q, err_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [15:0]         err_cnt_q, err_cnt_d;

  logic [N_SLOTS-1:0]  slot_sel;
  logic [DW-1:0]       sel_rd_data;
  logic                slot_hit;
  logic                in_access;

  always_comb begin
    slot_sel    = '0;
    sel_rd_data = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (slot_q == SLOT_AW'(i)) begin
        slot_sel[i] = 1'b1;
        sel_rd_data = slot_rd_data_array[i];
      end
    end
  end

  assign in_access = (state_q == ACCESS) && mapped_q;
  assign slot_hit  = |(slot_ready_array & slot_sel);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      mapped_q  <= 1'b0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      mapped_q  <= mapped_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    mapped_d  = mapped_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    wait_d    = wait_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (mmio_cs && (mmio_rd || mmio_wr)) begin
          slot_d   = mmio_addr[REG_AW +: SLOT_AW];
          reg_d    = mmio_addr[REG_AW-1:0];
          wdata_d  = mmio_wr_data;
          wr_d     = mmio_wr;
          rd_d     = mmio_rd && !mmio_wr;
          mapped_d = int'(mmio_addr[REG_AW +: SLOT_AW]) < N_SLOTS;
          wait_d   = '0;
          err_d    = 1'b0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        wait_d = wait_q + 1'b1;
        // Unmapped slots spend one strobe-less cycle here so every access has the same 2-cycle minimum.
        if (!mapped_q) begin
          err_d   = 1'b1;
          state_d = DONE;
          if (rd_q) rdata_d = ERR_DATA;
        end else if (slot_hit) begin
          err_d   = 1'b0;
          state_d = DONE;
          if (rd_q) rdata_d = sel_rd_data;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
          if (rd_q) rdata_d = ERR_DATA;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mmio_ready    = (state_q == DONE);
  assign mmio_err      = mmio_ready && err_q;
  assign mmio_rd_data  = rdata_q;
  assign err_count     = err_cnt_q;
  assign slot_cs_array = in_access ? slot_sel : '0;
  assign slot_mem_rd   = in_access && rd_q;
  assign slot_mem_wr   = in_access && wr_q;
  assign slot_reg_addr = reg_q;
  assign slot_wr_data  = wdata_q;

endmodule

// File: tb/tb_mmio_ctrl_wait.sv
// Bench for mmio_ctrl_wait: directed vector table, randomized accesses against a latency/error model,
// and hand sequences for idle requests, reset mid-access and error-counter saturation.
module tb_mmio_ctrl_wait;
  localparam int N_SLOTS = 40;
  localparam int SLOT_AW = 6;
  localparam int REG_AW  = 5;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int NEVER = 99;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        mmio_cs, mmio_wr, mmio_rd;
  logic [SLOT_AW+REG_AW-1:0]   mmio_addr;
  logic [DW-1:0]               mmio_wr_data;
  logic [DW-1:0]               mmio_rd_data;
  logic                        mmio_ready, mmio_err;
  logic [15:0]                 err_count;
  logic [N_SLOTS-1:0]          slot_cs_array;
  logic                        slot_mem_rd, slot_mem_wr;
  logic [REG_AW-1:0]           slot_reg_addr;
  logic [DW-1:0]               slot_wr_data;
  logic [N_SLOTS-1:0][DW-1:0]  slot_rd_data_array;
  logic [N_SLOTS-1:0]          slot_ready_array;

  mmio_ctrl_wait #(
    .N_SLOTS(N_SLOTS), .SLOT_AW(SLOT_AW), .REG_AW(REG_AW), .DW(DW),
    .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .reset(reset),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .mmio_ready(mmio_ready), .mmio_err(mmio_err),
    .err_count(err_count), .slot_cs_array(slot_cs_array),
    .slot_mem_rd(slot_mem_rd), .slot_mem_wr(slot_mem_wr),
    .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
    .slot_rd_data_array(slot_rd_data_array), .slot_ready_array(slot_ready_array)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  slot;
    logic [4:0]  regi;
    bit          rd;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_rdata;
    logic [15:0] exp_cnt;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_rd;
  logic [15:0] m_cnt;
  vec_t        tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outcome from the access rules: unmapped -> 2 cycles with error, ready after d
  // wait cycles -> d+2, never ready within TIMEOUT cycles -> TIMEOUT+1 with error.
  task automatic model(inout vec_t v);
    bit is_rd;
    is_rd = v.rd && !v.wr;
    if (int'(v.slot) >= N_SLOTS) begin
      v.exp_lat = 2; v.exp_err = 1'b1;
    end else if (v.delay < TIMEOUT) begin
      v.exp_lat = v.delay + 2; v.exp_err = 1'b0;
    end else begin
      v.exp_lat = TIMEOUT + 1; v.exp_err = 1'b1;
    end
    if (is_rd) m_rd = v.exp_err ? ERR_DATA : v.rdata;
    if (v.exp_err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    v.exp_rdata = m_rd;
    v.exp_cnt   = m_cnt;
  endtask

  task automatic run_vec(input vec_t v);
    int                 lat;
    bit                 done;
    bit                 mapped;
    logic [N_SLOTS-1:0] tgt;
    logic [N_SLOTS-1:0] noise;
    mapped = int'(v.slot) < N_SLOTS;
    tgt    = mapped ? (N_SLOTS'(1) << v.slot) : '0;
    @(negedge clk);
    mmio_cs = 1'b1; mmio_rd = v.rd; mmio_wr = v.wr;
    mmio_addr = {v.slot, v.regi}; mmio_wr_data = v.wdata;
    for (int s = 0; s < N_SLOTS; s++) slot_rd_data_array[s] = $urandom;
    if (mapped) slot_rd_data_array[v.slot] = v.rdata;
    slot_ready_array = '0;
    lat = 0; done = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
        mmio_addr = SLOT_AW+REG_AW'($urandom); mmio_wr_data = $urandom;
      end
      if (mmio_ready) begin
        lat = k; done = 1'b1;
      end else begin
        chk("slot_cs", 64'(slot_cs_array), 64'(tgt));
        chk("mem_rd", 64'(slot_mem_rd), 64'(mapped && v.rd && !v.wr));
        chk("mem_wr", 64'(slot_mem_wr), 64'(mapped && v.wr));
        if (mapped) begin
          chk("reg_addr", 64'(slot_reg_addr), 64'(v.regi));
          chk("wr_data", 64'(slot_wr_data), 64'(v.wdata));
        end
        noise = N_SLOTS'({$urandom, $urandom});
        slot_ready_array = (noise & ~tgt) | ((k == v.delay + 1) ? tgt : '0);
      end
    end
    slot_ready_array = '0;
    chk("latency", 64'(lat), 64'(v.exp_lat));
    if (done) begin
      chk("mmio_err", 64'(mmio_err), 64'(v.exp_err));
      chk("rd_data", 64'(mmio_rd_data), 64'(v.exp_rdata));
    end
    @(negedge clk);
    chk("ready_pulse", 64'(mmio_ready), 64'(0));
    chk("err_count", 64'(err_count), 64'(v.exp_cnt));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cs"}, 64'(slot_cs_array), 64'(0));
    chk({tag, "_strobes"}, 64'({slot_mem_rd, slot_mem_wr, mmio_ready, mmio_err}), 64'(0));
    chk({tag, "_cnt"}, 64'(err_count), 64'(0));
    chk({tag, "_rdata"}, 64'(mmio_rd_data), 64'(0));
    chk({tag, "_latched"}, 64'({slot_reg_addr, slot_wr_data}), 64'(0));
  endtask

  initial begin
    vec_t v;
    reset = 1'b0; mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
    mmio_addr = '0; mmio_wr_data = '0;
    slot_rd_data_array = '0; slot_ready_array = '0;

    //             slot   reg   rd wr wdata          rdata          dly    lat err exp_rdata      cnt
    tbl[0] = '{6'd3,  5'd7,  1, 0, 32'h0,         32'h1234_5678, 0,     2, 0, 32'h1234_5678, 16'd0};
    tbl[1] = '{6'd10, 5'd2,  0, 1, 32'hCAFE_F00D, 32'h0,         5,     7, 0, 32'h1234_5678, 16'd0};
    tbl[2] = '{6'd2,  5'd0,  1, 0, 32'h0,         32'h7777_0000, NEVER, 9, 1, 32'hDEAD_BEEF, 16'd1};
    tbl[3] = '{6'd5,  5'd9,  1, 0, 32'h0,         32'h0000_0001, 1,     3, 0, 32'h0000_0001, 16'd1};
    tbl[4] = '{6'd50, 5'd4,  1, 0, 32'h0,         32'h0,         0,     2, 1, 32'hDEAD_BEEF, 16'd2};
    tbl[5] = '{6'd1,  5'd3,  1, 1, 32'h55AA_55AA, 32'h1111_2222, 2,     4, 0, 32'hDEAD_BEEF, 16'd2};
    tbl[6] = '{6'd1,  5'd3,  1, 0, 32'h0,         32'hA5A5_A5A5, 7,     9, 0, 32'hA5A5_A5A5, 16'd2};
    tbl[7] = '{6'd60, 5'd1,  0, 1, 32'h0BAD_0BAD, 32'h0,         0,     2, 1, 32'hA5A5_A5A5, 16'd3};
    tbl[8] = '{6'd39, 5'd30, 0, 1, 32'h0F0F_0F0F, 32'h0,         NEVER, 9, 1, 32'hA5A5_A5A5, 16'd4};
    tbl[9] = '{6'd0,  5'd31, 1, 0, 32'h0,         32'h0000_0000, 3,     5, 0, 32'h0000_0000, 16'd4};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    // Select without an operation must not start an access.
    @(negedge clk);
    mmio_cs = 1'b1; mmio_addr = {6'd4, 5'd0};
    repeat (3) begin
      @(negedge clk);
      chk("idle_cs", 64'({slot_cs_array, mmio_ready}), 64'(0));
    end
    mmio_cs = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    m_rd = tbl[9].exp_rdata; m_cnt = tbl[9].exp_cnt;
    for (int i = 0; i < 60; i++) begin
      v.slot  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(N_SLOTS, 63)) : 6'($urandom_range(0, N_SLOTS - 1));
      v.regi  = 5'($urandom);
      v.rd    = $urandom_range(0, 1);
      v.wr    = v.rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.delay = ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(0, TIMEOUT - 1);
      model(v);
      run_vec(v);
    end

    // Reset while a slot is strobed: everything drops at once, next access is clean.
    @(negedge clk);
    mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_addr = {6'd4, 5'd6};
    @(negedge clk);
    mmio_cs = 1'b0; mmio_rd = 1'b0;
    @(negedge clk);
    chk("pre_reset_cs", 64'(slot_cs_array), 64'(N_SLOTS'(1) << 4));
    #2 reset = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    m_rd = '0; m_cnt = '0;
    v = '{6'd4, 5'd6, 1, 0, 32'h0, 32'h4444_0004, 0, 0, 0, 32'h0, 16'd0};
    model(v);
    run_vec(v);

    // Error counter saturation.
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFE;
    #1 release dut.err_cnt_q;
    m_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      v = '{6'd45, 5'd0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 16'd0};
      model(v);
      run_vec(v);
    end
    chk("sat_hold", 64'(err_count), 64'(16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
